// File: rtl/cut_scan_if.sv
// Handshake, data and scan signals of the cut_scan line-acquisition controller.
// The bench drives through master; the controller sits behind slave.
interface cut_scan_if;
    logic       s;
    logic       dv;
    logic       l_in;
    logic [1:0] test_in;
    logic       fz_L;
    logic       lclk;
    logic [4:0] read_a;
    logic [1:0] test_out;

    modport master (
        output s, dv, l_in, test_in,
        input  fz_L, lclk, read_a, test_out
    );

    modport slave (
        input  s, dv, l_in, test_in,
        output fz_L, lclk, read_a, test_out
    );
endinterface

// File: rtl/cut_scan.sv
// Line-acquisition controller (circuit under test for scan BIST).
// All ten flops are muxed-D scan cells in two 5-deep chains.
module cut_scan (
    input  logic   clock,
    input  logic   reset,
    cut_scan_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ACQ     = 2'b01,
        HOLD    = 2'b10,
        ILLEGAL = 2'b11
    } state_t;

    state_t     st;
    logic [4:0] addr;
    logic       lclk_r;
    logic       l_q;
    logic       fz;

    always_ff @(posedge clock) begin
        if (!reset) begin
            st     <= IDLE;
            addr   <= 5'd0;
            lclk_r <= 1'b0;
            l_q    <= 1'b0;
            fz     <= 1'b1;
        end else if (bus.s) begin
            // chain0: test_in[0] -> st[0] -> st[1] -> l_q -> fz -> lclk_r
            st     <= state_t'({st[0], bus.test_in[0]});
            l_q    <= st[1];
            fz     <= l_q;
            lclk_r <= fz;
            // chain1: test_in[1] -> addr[0] .. addr[4]
            addr   <= {addr[3:0], bus.test_in[1]};
        end else begin
            l_q <= bus.l_in;
            case (st)
                IDLE: begin
                    addr   <= 5'd0;
                    lclk_r <= 1'b0;
                    if (bus.dv) begin
                        st <= ACQ;
                        fz <= 1'b0;
                    end else begin
                        fz <= 1'b1;
                    end
                end
                ACQ: begin
                    // l_q wins over the end-of-line address so an early line end never advances
                    if (l_q) begin
                        st     <= HOLD;
                        lclk_r <= 1'b0;
                    end else if (lclk_r && (addr == 5'd31)) begin
                        st     <= HOLD;
                        lclk_r <= 1'b0;
                    end else if (lclk_r) begin
                        lclk_r <= 1'b0;
                        addr   <= addr + 5'd1;
                    end else begin
                        lclk_r <= 1'b1;
                    end
                end
                HOLD: begin
                    lclk_r <= 1'b0;
                    if (!bus.dv) begin
                        st   <= IDLE;
                        fz   <= 1'b1;
                        addr <= 5'd0;
                    end else begin
                        fz <= 1'b0;
                    end
                end
                default: begin
                    st     <= IDLE;
                    addr   <= 5'd0;
                    lclk_r <= 1'b0;
                    fz     <= 1'b1;
                end
            endcase
        end
    end

    assign bus.fz_L     = fz;
    assign bus.lclk     = lclk_r;
    assign bus.read_a   = addr;
    assign bus.test_out = {addr[4], lclk_r};
endmodule

// File: tb/tb_cut_scan.sv
// Self-checking bench for cut_scan: directed scenarios plus random traffic
// compared every clock against a behavioural model of the controller.
module tb_cut_scan;
    logic clock = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    cut_scan_if bus ();

    cut_scan dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    // Reference model: state as integer 0=idle 1=acq 2=hold 3=illegal
    int m_st;
    int m_addr;
    bit m_lclk, m_lq, m_fz;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clock();
        bit [4:0] c0;
        bit       lq_prev;
        if (!reset) begin
            m_st = 0; m_addr = 0; m_lclk = 0; m_lq = 0; m_fz = 1;
        end else if (bus.s) begin
            // chain0 as a list (st0, st1, l_q, fz, lclk): new head enters, everything moves one deeper
            c0     = {m_lclk, m_fz, m_lq, m_st[1], m_st[0]};
            c0     = {c0[3:0], bus.test_in[0]};
            m_st   = int'(c0[1:0]);
            m_lq   = c0[2];
            m_fz   = c0[3];
            m_lclk = c0[4];
            m_addr = (m_addr * 2 + int'(bus.test_in[1])) % 32;
        end else begin
            lq_prev = m_lq;
            m_lq    = bus.l_in;
            case (m_st)
                0: begin
                    m_addr = 0; m_lclk = 0;
                    if (bus.dv) begin m_st = 1; m_fz = 0; end
                    else m_fz = 1;
                end
                1: begin
                    if (lq_prev) begin m_st = 2; m_lclk = 0; end
                    else if (m_lclk && m_addr == 31) begin m_st = 2; m_lclk = 0; end
                    else if (m_lclk) begin m_lclk = 0; m_addr = m_addr + 1; end
                    else m_lclk = 1;
                end
                2: begin
                    m_lclk = 0;
                    if (!bus.dv) begin m_st = 0; m_fz = 1; m_addr = 0; end
                    else m_fz = 0;
                end
                default: begin
                    m_st = 0; m_addr = 0; m_lclk = 0; m_fz = 1;
                end
            endcase
        end
    endtask

    // Advance one clock with the inputs as currently driven, then compare all outputs
    task automatic step(input string tag);
        model_clock();
        @(posedge clock);
        #1;
        check_eq({tag, ".fz_L"}, 32'(bus.fz_L), 32'(m_fz));
        check_eq({tag, ".lclk"}, 32'(bus.lclk), 32'(m_lclk));
        check_eq({tag, ".read_a"}, 32'(bus.read_a), 32'(m_addr));
        check_eq({tag, ".test_out"}, 32'(bus.test_out), 32'({m_addr[4], m_lclk}));
    endtask

    // c0 bits: [0]=st0 [1]=st1 [2]=l_q [3]=fz [4]=lclk_r; deepest cells go in first
    task automatic scan_load(input logic [4:0] c0, input logic [4:0] a);
        bus.s = 1'b1;
        for (int i = 4; i >= 0; i--) begin
            bus.test_in = {a[i], c0[i]};
            step("scan_load");
        end
        bus.test_in = 2'b00;
    endtask

    initial begin
        reset = 1'b0;
        bus.s = 1'b0; bus.dv = 1'b0; bus.l_in = 1'b0; bus.test_in = 2'b00;

        // reset then idle
        step("reset"); step("reset");
        check_eq("rst_fz_L", 32'(bus.fz_L), 32'd1);
        check_eq("rst_test_out", 32'(bus.test_out), 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) step("idle");
        check_eq("idle_read_a", 32'(bus.read_a), 32'd0);
        check_eq("idle_lclk", 32'(bus.lclk), 32'd0);

        // full line from a single-clock dv pulse
        bus.dv = 1'b1;
        step("start");
        check_eq("start_fz_L", 32'(bus.fz_L), 32'd0);
        bus.dv = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (i == 60) bus.dv = 1'b1;
            step("line");
        end
        check_eq("line_end_read_a", 32'(bus.read_a), 32'd31);
        check_eq("line_end_lclk", 32'(bus.lclk), 32'd0);
        check_eq("line_end_fz_L", 32'(bus.fz_L), 32'd0);
        step("hold");
        check_eq("hold_read_a", 32'(bus.read_a), 32'd31);
        bus.dv = 1'b0;
        step("release");
        check_eq("release_fz_L", 32'(bus.fz_L), 32'd1);
        check_eq("release_read_a", 32'(bus.read_a), 32'd0);

        // early line end
        bus.dv = 1'b1;
        step("early_start");
        begin
            int n = 0;
            while (bus.read_a != 5'd5 && n < 40) begin step("early_run"); n++; end
            check_eq("early_reach5", 32'(bus.read_a), 32'd5);
        end
        bus.l_in = 1'b1;
        step("early_l"); step("early_l");
        bus.l_in = 1'b0;
        check_eq("early_lclk", 32'(bus.lclk), 32'd0);
        check_eq("early_addr_5or6", 32'(bus.read_a == 5'd5 || bus.read_a == 5'd6), 32'd1);
        for (int i = 0; i < 3; i++) step("early_hold");
        check_eq("early_fz_L", 32'(bus.fz_L), 32'd0);
        bus.dv = 1'b0;
        step("early_release");

        // scan shift: chain length and ordering
        bus.s = 1'b1; bus.test_in = 2'b11;
        for (int i = 0; i < 4; i++) step("shift_ones");
        check_eq("shift_4th", 32'(bus.test_out), 32'd0);
        step("shift_ones");
        check_eq("shift_5th", 32'(bus.test_out), 32'd3);
        bus.test_in = 2'b00;
        for (int i = 0; i < 4; i++) step("shift_zeros");
        check_eq("shift_z4", 32'(bus.test_out), 32'd3);
        step("shift_zeros");
        check_eq("shift_z5", 32'(bus.test_out), 32'd0);

        // scan load ACQ/addr=31/lclk=1, capture one functional clock, shift out
        scan_load(5'b10001, 5'd31);
        bus.s = 1'b0; bus.dv = 1'b1;
        step("capture");
        check_eq("cap_read_a", 32'(bus.read_a), 32'd31);
        check_eq("cap_lclk", 32'(bus.lclk), 32'd0);
        bus.s = 1'b1;
        for (int i = 0; i < 5; i++) step("unload");
        bus.s = 1'b0; bus.dv = 1'b0;
        step("post_unload");

        // reset has priority over scan, mid-acquisition
        reset = 1'b0; step("re_reset"); reset = 1'b1;
        bus.dv = 1'b1; step("mid_start"); bus.dv = 1'b0;
        for (int i = 0; i < 7; i++) step("mid_run");
        bus.s = 1'b1; reset = 1'b0;
        step("mid_reset");
        check_eq("mid_reset_fz_L", 32'(bus.fz_L), 32'd1);
        check_eq("mid_reset_read_a", 32'(bus.read_a), 32'd0);
        reset = 1'b1;

        // illegal state recovery
        scan_load(5'b00011, 5'd7);
        bus.s = 1'b0;
        step("illegal");
        check_eq("illegal_fz_L", 32'(bus.fz_L), 32'd1);
        check_eq("illegal_read_a", 32'(bus.read_a), 32'd0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            bus.s       = ($urandom_range(0, 99) < 8) ? 1'b1 : 1'b0;
            bus.dv      = ($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0;
            bus.l_in    = ($urandom_range(0, 99) < 5) ? 1'b1 : 1'b0;
            bus.test_in = 2'($urandom_range(0, 3));
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
